// File: rtl/dark_pixel_centroid_if.sv
`default_nettype none
// ============================================================================
// Module      : dark_pixel_centroid_if
// Description : Pixel stream, frame control and centroid result bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface dark_pixel_centroid_if;
    logic       frame_capture_start;
    logic       pixel_valid;
    logic [7:0] pixel_data;
    logic [7:0] threshold;
    logic [6:0] resolution;
    logic       busy;
    logic [7:0] pupil_location_horizontal;
    logic [7:0] pupil_location_vertical;
    logic       location_found;
    logic [13:0] dark_count;
    logic       result_valid;

    modport master (
        output frame_capture_start, pixel_valid, pixel_data, threshold, resolution,
        input  busy, pupil_location_horizontal, pupil_location_vertical,
               location_found, dark_count, result_valid
    );

    modport slave (
        input  frame_capture_start, pixel_valid, pixel_data, threshold, resolution,
        output busy, pupil_location_horizontal, pupil_location_vertical,
               location_found, dark_count, result_valid
    );
endinterface
`default_nettype wire

// File: rtl/dark_pixel_centroid.sv
`default_nettype none
// ============================================================================
// Module      : dark_pixel_centroid
// Description : Accumulates dark-pixel coordinates over a frame and divides by
//               the dark count to report the pupil centroid.
// Revision    : 1.0 - initial release
// ============================================================================
module dark_pixel_centroid #(
    parameter int MAX_RESOLUTION = 112
) (
    input  wire logic           clk,
    input  wire logic           reset,
    dark_pixel_centroid_if.slave bus
);

    localparam logic [6:0] c_max_res  = 7'(MAX_RESOLUTION);
    localparam logic [4:0] c_div_last = 5'd20;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        DIV_H = 3'd2,
        DIV_V = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [6:0]  r_res;
    logic [7:0]  r_threshold;
    logic [6:0]  r_row;
    logic [6:0]  r_col;
    logic [20:0] r_col_sum;
    logic [20:0] r_row_sum;
    logic [13:0] r_count;
    logic [21:0] r_rem;
    logic [4:0]  r_step;

    logic [7:0]  r_h;
    logic [7:0]  r_v;
    logic        r_found;
    logic [13:0] r_dark_count;
    logic        r_result_valid;

    logic [6:0]  w_res_sel;
    logic        w_accept;
    logic        w_dark;
    logic        w_col_last;
    logic        w_last_pixel;
    logic        w_div_done;
    logic [20:0] w_dividend;
    logic [21:0] w_shift;
    logic [22:0] w_trial;
    logic [21:0] w_rem_next;
    logic [20:0] w_quo_next;

    assign w_res_sel    = (bus.resolution < 7'd2 || bus.resolution > c_max_res) ?
                          c_max_res : bus.resolution;
    assign w_accept     = (r_state == ACCUM) && !bus.frame_capture_start && bus.pixel_valid;
    assign w_dark       = bus.pixel_data < r_threshold;
    assign w_col_last   = (r_col == r_res - 7'd1);
    assign w_last_pixel = w_col_last && (r_row == r_res - 7'd1);
    assign w_div_done   = (r_step == c_div_last);

    // One restoring-divide step; the dividend register shifts out its MSB and
    // fills with quotient bits, so it holds the quotient after 21 steps.
    assign w_dividend = (r_state == DIV_H) ? r_col_sum : r_row_sum;
    assign w_shift    = {r_rem[20:0], w_dividend[20]};
    assign w_trial    = {1'b0, w_shift} - {9'd0, r_count};
    assign w_rem_next = w_trial[22] ? w_shift : w_trial[21:0];
    assign w_quo_next = {w_dividend[19:0], ~w_trial[22]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.frame_capture_start) w_next_state = ACCUM;
            ACCUM:   if (w_accept && w_last_pixel) w_next_state = DIV_H;
            DIV_H:   if (w_div_done) w_next_state = DIV_V;
            DIV_V:   if (w_div_done) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_res          <= c_max_res;
            r_threshold    <= 8'd0;
            r_row          <= 7'd0;
            r_col          <= 7'd0;
            r_col_sum      <= 21'd0;
            r_row_sum      <= 21'd0;
            r_count        <= 14'd0;
            r_rem          <= 22'd0;
            r_step         <= 5'd0;
            r_h            <= 8'hFF;
            r_v            <= 8'hFF;
            r_found        <= 1'b0;
            r_dark_count   <= 14'd0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                IDLE, ACCUM: begin
                    if (bus.frame_capture_start) begin
                        r_res       <= w_res_sel;
                        r_threshold <= bus.threshold;
                        r_row       <= 7'd0;
                        r_col       <= 7'd0;
                        r_col_sum   <= 21'd0;
                        r_row_sum   <= 21'd0;
                        r_count     <= 14'd0;
                        r_rem       <= 22'd0;
                        r_step      <= 5'd0;
                    end else if (w_accept) begin
                        if (w_dark) begin
                            r_col_sum <= r_col_sum + {14'd0, r_col};
                            r_row_sum <= r_row_sum + {14'd0, r_row};
                            r_count   <= r_count + 14'd1;
                        end
                        if (w_col_last) begin
                            r_col <= 7'd0;
                            r_row <= r_row + 7'd1;
                        end else begin
                            r_col <= r_col + 7'd1;
                        end
                    end
                end
                DIV_H, DIV_V: begin
                    if (r_state == DIV_H) begin
                        r_col_sum <= w_quo_next;
                    end else begin
                        r_row_sum <= w_quo_next;
                    end
                    if (w_div_done) begin
                        r_rem  <= 22'd0;
                        r_step <= 5'd0;
                    end else begin
                        r_rem  <= w_rem_next;
                        r_step <= r_step + 5'd1;
                    end
                    // Results are registered on the final DIV_V step so they are
                    // already stable during the DONE cycle that flags them.
                    if (r_state == DIV_V && w_div_done) begin
                        r_found        <= (r_count != 14'd0);
                        r_h            <= (r_count != 14'd0) ? r_col_sum[7:0]  : 8'hFF;
                        r_v            <= (r_count != 14'd0) ? w_quo_next[7:0] : 8'hFF;
                        r_dark_count   <= r_count;
                        r_result_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy                      = (r_state != IDLE);
    assign bus.pupil_location_horizontal = r_h;
    assign bus.pupil_location_vertical   = r_v;
    assign bus.location_found            = r_found;
    assign bus.dark_count                = r_dark_count;
    assign bus.result_valid              = r_result_valid;

endmodule
`default_nettype wire

// File: tb/tb_dark_pixel_centroid.sv
`default_nettype none
// ============================================================================
// Module      : tb_dark_pixel_centroid
// Description : Directed frame vectors plus restart/reset/ignore sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dark_pixel_centroid;

    typedef struct {
        int res;
        int thr;
        int dval;
        int bval;
        int d0;
        int d1;
        int d2;
        bit gaps;
        int eh;
        int ev;
        int ef;
        int ec;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   rv_count = 0;
    int   rv_cyc = 0;
    int   rv_base = 0;
    int   last_cyc = 0;
    int   snap_h, snap_v, snap_f, snap_c;
    vec_t vecs[8];

    dark_pixel_centroid_if bus();

    dark_pixel_centroid #(.MAX_RESOLUTION(112)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.result_valid) begin
            rv_count++;
            rv_cyc = cyc;
            snap_h = int'(bus.pupil_location_horizontal);
            snap_v = int'(bus.pupil_location_vertical);
            snap_f = int'(bus.location_found);
            snap_c = int'(bus.dark_count);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start pulse carries a dark pixel_valid that must never be counted.
    task automatic send_frame(input vec_t v);
        int eff;
        rv_base = rv_count;
        bus.frame_capture_start = 1'b1;
        bus.resolution = 7'(v.res);
        bus.threshold  = 8'(v.thr);
        bus.pixel_valid = 1'b1;
        bus.pixel_data  = 8'd0;
        tick();
        bus.frame_capture_start = 1'b0;
        eff = (v.res < 2 || v.res > 112) ? 112 : v.res;
        for (int p = 0; p < eff * eff; p++) begin
            if (v.gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.pixel_valid = 1'b0;
                    bus.pixel_data  = 8'd0;
                    tick();
                end
            end
            bus.pixel_valid = 1'b1;
            bus.pixel_data  = (p == v.d0 || p == v.d1 || p == v.d2) ? 8'(v.dval) : 8'(v.bval);
            last_cyc = cyc;
            tick();
        end
        bus.pixel_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input vec_t v);
        for (int i = 0; i < 100 && rv_count == rv_base; i++) tick();
        check({name, " result_seen"}, rv_count - rv_base, 1);
        repeat (5) tick();
        check({name, " single_pulse"}, rv_count - rv_base, 1);
        check({name, " latency"}, rv_cyc - last_cyc, 43);
        check({name, " h"}, snap_h, v.eh);
        check({name, " v"}, snap_v, v.ev);
        check({name, " found"}, snap_f, v.ef);
        check({name, " dark_count"}, snap_c, v.ec);
        check({name, " h_hold"}, int'(bus.pupil_location_horizontal), v.eh);
        check({name, " busy_after"}, int'(bus.busy), 0);
    endtask

    initial begin
        vec_t s;
        int   base;

        vecs[0] = '{4,   10,  5, 200, 11, -1, -1, 1'b0,   3,   2, 1,     1};
        vecs[1] = '{4,   10,  5, 200,  0,  5, 15, 1'b0,   1,   1, 1,     3};
        vecs[2] = '{4,   10,255, 255, -1, -1, -1, 1'b0, 255, 255, 0,     0};
        vecs[3] = '{112, 255, 0,   0, -1, -1, -1, 1'b0,  55,  55, 1, 12544};
        vecs[4] = '{112, 255, 0,   0, -1, -1, -1, 1'b1,  55,  55, 1, 12544};
        vecs[5] = '{4,   10,  9,  10,  9, -1, -1, 1'b0,   1,   2, 1,     1};
        vecs[6] = '{2,  100,  5, 200,  3, -1, -1, 1'b1,   1,   1, 1,     1};
        vecs[7] = '{120,  10,  5, 200,  0, -1, -1, 1'b0,   0,   0, 1,     1};

        reset = 1'b1;
        bus.frame_capture_start = 1'b1;
        bus.pixel_valid = 1'b1;
        bus.pixel_data  = 8'd0;
        bus.threshold   = 8'd10;
        bus.resolution  = 7'd4;
        repeat (3) tick();
        check("reset_priority busy", int'(bus.busy), 0);
        reset = 1'b0;
        bus.frame_capture_start = 1'b0;
        bus.pixel_valid = 1'b0;
        tick();
        check("reset busy", int'(bus.busy), 0);
        check("reset result_valid", int'(bus.result_valid), 0);
        check("reset found", int'(bus.location_found), 0);
        check("reset dark_count", int'(bus.dark_count), 0);
        check("reset h", int'(bus.pupil_location_horizontal), 255);
        check("reset v", int'(bus.pupil_location_vertical), 255);

        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i]);
            wait_result($sformatf("vec%0d", i), vecs[i]);
        end

        // Restart after 7 dark pixels; only the second frame may count.
        bus.frame_capture_start = 1'b1;
        bus.resolution = 7'd4;
        bus.threshold  = 8'd10;
        tick();
        bus.frame_capture_start = 1'b0;
        for (int p = 0; p < 7; p++) begin
            bus.pixel_valid = 1'b1;
            bus.pixel_data  = 8'd0;
            tick();
        end
        s = '{4, 10, 5, 200, 6, -1, -1, 1'b0, 2, 1, 1, 1};
        send_frame(s);
        wait_result("restart", s);

        // frame_capture_start while dividing must not disturb the result.
        s = '{4, 10, 5, 200, 11, -1, -1, 1'b0, 3, 2, 1, 1};
        send_frame(s);
        repeat (5) tick();
        bus.frame_capture_start = 1'b1;
        bus.resolution = 7'd2;
        bus.threshold  = 8'd255;
        tick();
        bus.frame_capture_start = 1'b0;
        wait_result("start_in_div", s);

        // Reset while in DIV_V aborts the frame silently.
        s = '{4, 10, 5, 200, 6, -1, -1, 1'b0, 2, 1, 1, 1};
        send_frame(s);
        repeat (25) tick();
        check("pre_abort busy", int'(bus.busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", int'(bus.busy), 0);
        check("abort h", int'(bus.pupil_location_horizontal), 255);
        check("abort v", int'(bus.pupil_location_vertical), 255);
        check("abort found", int'(bus.location_found), 0);
        check("abort dark_count", int'(bus.dark_count), 0);
        base = rv_count;
        repeat (60) tick();
        check("abort no_result", rv_count - base, 0);
        for (int i = 0; i < 5; i++) begin
            bus.pixel_valid = 1'b1;
            bus.pixel_data  = 8'd0;
            tick();
            check("idle_pixel busy", int'(bus.busy), 0);
        end
        bus.pixel_valid = 1'b0;
        repeat (50) tick();
        check("idle_pixel no_result", rv_count - base, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
